// File: rtl/pcr_pkg.sv
// Shared constants, FSM encoding and delay-line word for the PCR restamper.
// Also holds the byte picker used when substituting the rewritten PCR field.
package pcr_pkg;

    localparam logic [7:0] TS_SYNC       = 8'h47;
    localparam logic [7:0] TS_PKT_LEN    = 8'd188;
    localparam logic [7:0] TS_LAST_IDX   = TS_PKT_LEN - 8'd1;
    localparam logic [8:0] PCR_EXT_MOD   = 9'd300;
    localparam logic [7:0] PCR_FIRST_IDX = 8'd6;
    localparam logic [7:0] PCR_LAST_IDX  = 8'd11;
    localparam logic [2:0] PCR_LAST_POS  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_AF_LEN   = 3'd2,
        ST_AF_FLAGS = 3'd3,
        ST_PCR_CAP  = 3'd4,
        ST_PAYLOAD  = 3'd5
    } pcr_state_e;

    // pos is 1..6 for PCR bytes 6..11 of a packet whose PCR was captured, 0 otherwise
    typedef struct packed {
        logic [7:0] data;
        logic       en;
        logic       sop;
        logic [2:0] pos;
    } dl_word_t;

    function automatic logic [7:0] pcr_byte_sel(input logic [47:0] pcr, input logic [2:0] pos);
        logic [7:0] b;
        case (pos)
            3'd1:    b = pcr[47:40];
            3'd2:    b = pcr[39:32];
            3'd3:    b = pcr[31:24];
            3'd4:    b = pcr[23:16];
            3'd5:    b = pcr[15:8];
            3'd6:    b = pcr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pcr_arith.sv
// Two-stage PCR correction: delta = now - stamp (+ offset), then PCR + delta,
// with the extension kept mod 300 and the base mod 2^33.
module pcr_arith
    import pcr_pkg::*;
#(
    parameter logic [8:0] OFFSET_EXT = 9'd8
) (
    input  logic        clk_main_a,
    input  logic        rst_gen,
    input  logic        start,
    input  logic [47:0] pcr,
    input  logic [32:0] stamp_base,
    input  logic [8:0]  stamp_ext,
    input  logic [32:0] now_base,
    input  logic [8:0]  now_ext,
    output logic [47:0] result,
    output logic        done
);

    logic [11:0] ext_raw_s;
    logic [8:0]  d_ext_s;
    logic [32:0] d_base_s;
    logic [8:0]  d_ext_r;
    logic [32:0] d_base_r;
    logic [47:0] pcr_r;
    logic        vld1_r;
    logic [9:0]  sum_ext_s;
    logic [8:0]  s_ext_s;
    logic        carry_s;
    logic [32:0] s_base_s;
    logic [47:0] result_r;
    logic        done_r;

    // Stage 1 delta; ext is biased by +300 so the borrow case stays unsigned
    always_comb begin
        ext_raw_s = {3'b000, now_ext} + {3'b000, OFFSET_EXT} + {3'b000, PCR_EXT_MOD}
                    - {3'b000, stamp_ext};
        d_base_s  = now_base - stamp_base;
        if (ext_raw_s < {3'b000, PCR_EXT_MOD}) begin
            d_ext_s  = ext_raw_s[8:0];
            d_base_s = d_base_s - 33'd1;
        end else if (ext_raw_s >= {2'b00, PCR_EXT_MOD, 1'b0}) begin
            d_ext_s  = 9'(ext_raw_s - {2'b00, PCR_EXT_MOD, 1'b0});
            d_base_s = d_base_s + 33'd1;
        end else begin
            d_ext_s  = 9'(ext_raw_s - {3'b000, PCR_EXT_MOD});
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            d_ext_r  <= 9'd0;
            d_base_r <= 33'd0;
            pcr_r    <= 48'd0;
            vld1_r   <= 1'b0;
        end else begin
            vld1_r <= start;
            if (start) begin
                d_ext_r  <= d_ext_s;
                d_base_r <= d_base_s;
                pcr_r    <= pcr;
            end
        end
    end

    // Stage 2 add of the delta onto the captured PCR
    always_comb begin
        sum_ext_s = {1'b0, pcr_r[8:0]} + {1'b0, d_ext_r};
        if (sum_ext_s >= {1'b0, PCR_EXT_MOD}) begin
            s_ext_s = 9'(sum_ext_s - {1'b0, PCR_EXT_MOD});
            carry_s = 1'b1;
        end else begin
            s_ext_s = sum_ext_s[8:0];
            carry_s = 1'b0;
        end
        s_base_s = pcr_r[47:15] + d_base_r + {32'd0, carry_s};
    end

    // Stage 2 registers; result holds until the next capture
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            result_r <= 48'd0;
            done_r   <= 1'b0;
        end else begin
            done_r <= vld1_r;
            if (vld1_r) begin
                result_r <= {s_base_s, pcr_r[14:9], s_ext_s};
            end
        end
    end

    assign result = result_r;
    assign done   = done_r;

endmodule

// File: rtl/pcr_restamp.sv
// Read-side PCR corrector: parses each TS packet, restamps its PCR with the
// time spent in the buffer, and passes every byte through a fixed LAT delay.
module pcr_restamp
    import pcr_pkg::*;
#(
    parameter int         LAT            = 8,
    parameter logic [8:0] PCR_OFFSET_EXT = 9'd8
) (
    input  logic        clk_main_a,
    input  logic        rst_gen,
    input  logic [7:0]  ts_din,
    input  logic        ts_din_en,
    input  logic        ts_din_sop,
    input  logic [32:0] stamp_base,
    input  logic [8:0]  stamp_ext,
    input  logic [32:0] pcr_base_cnt,
    input  logic [8:0]  pcr_ext_cnt,
    output logic [7:0]  ts_dout,
    output logic        ts_dout_en,
    output logic        ts_dout_sop,
    output logic        pcr_upd,
    output logic        err_sync,
    output logic        err_gap
);

    pcr_state_e  state_r, state_nxt_s;
    logic [7:0]  idx_r, cur_idx_s;
    logic [32:0] stamp_base_r;
    logic [8:0]  stamp_ext_r;
    logic [39:0] pcr_sr_r;
    logic        err_sync_s, err_gap_s, cap_s, start_s;
    logic [2:0]  pos_s;
    logic        err_sync_r, err_gap_r;
    logic        pend_r, rewrite_r, rw_eff_s, sub_s;
    logic [47:0] arith_result_s;
    logic        arith_done_s;
    dl_word_t    dl_in_s, dl_tail_s;
    dl_word_t    dl_r [LAT-1];
    logic [7:0]  dout_r;
    logic        dout_en_r, dout_sop_r, pcr_upd_r;

    // Index of the byte currently on the input
    always_comb begin
        if (ts_din_sop) begin
            cur_idx_s = 8'd0;
        end else begin
            cur_idx_s = 8'(idx_r + 8'd1);
        end
    end

    // FSM state register
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; sop restarts parsing from any state
    always_comb begin
        state_nxt_s = state_r;
        if (ts_din_en && ts_din_sop) begin
            state_nxt_s = (ts_din == TS_SYNC) ? ST_HDR : ST_PAYLOAD;
        end else if (ts_din_en) begin
            case (state_r)
                ST_IDLE:     state_nxt_s = ST_IDLE;
                ST_HDR:      state_nxt_s = (cur_idx_s != 8'd3) ? ST_HDR :
                                           (ts_din[5] ? ST_AF_LEN : ST_PAYLOAD);
                ST_AF_LEN:   state_nxt_s = (ts_din == 8'd0) ? ST_PAYLOAD : ST_AF_FLAGS;
                ST_AF_FLAGS: state_nxt_s = ts_din[4] ? ST_PCR_CAP : ST_PAYLOAD;
                ST_PCR_CAP:  state_nxt_s = (cur_idx_s == PCR_LAST_IDX) ? ST_PAYLOAD : ST_PCR_CAP;
                ST_PAYLOAD:  state_nxt_s = (cur_idx_s == TS_LAST_IDX) ? ST_IDLE : ST_PAYLOAD;
                default:     state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // FSM outputs: error strobes, PCR capture tagging, arithmetic kick-off
    always_comb begin
        err_sync_s = 1'b0;
        err_gap_s  = 1'b0;
        cap_s      = 1'b0;
        if (ts_din_en) begin
            if (ts_din_sop) begin
                err_sync_s = (ts_din != TS_SYNC);
            end else begin
                cap_s = (state_r == ST_PCR_CAP);
            end
        end else begin
            err_gap_s = (state_r != ST_IDLE);
        end
        if (cap_s) begin
            pos_s   = 3'(cur_idx_s - PCR_FIRST_IDX + 8'd1);
            start_s = (cur_idx_s == PCR_LAST_IDX);
        end else begin
            pos_s   = 3'd0;
            start_s = 1'b0;
        end
    end

    // Byte index, arrival stamp and PCR capture
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            idx_r        <= 8'd0;
            stamp_base_r <= 33'd0;
            stamp_ext_r  <= 9'd0;
            pcr_sr_r     <= 40'd0;
        end else begin
            if (ts_din_en) begin
                idx_r <= cur_idx_s;
            end
            if (ts_din_en && ts_din_sop) begin
                stamp_base_r <= stamp_base;
                stamp_ext_r  <= stamp_ext;
            end
            if (cap_s) begin
                pcr_sr_r <= {pcr_sr_r[31:0], ts_din};
            end
        end
    end

    pcr_arith #(
        .OFFSET_EXT (PCR_OFFSET_EXT)
    ) u_arith (
        .clk_main_a (clk_main_a),
        .rst_gen    (rst_gen),
        .start      (start_s),
        .pcr        ({pcr_sr_r, ts_din}),
        .stamp_base (stamp_base_r),
        .stamp_ext  (stamp_ext_r),
        .now_base   (pcr_base_cnt),
        .now_ext    (pcr_ext_cnt),
        .result     (arith_result_s),
        .done       (arith_done_s)
    );

    // Rewrite bookkeeping; a gap cancels both an in-flight and a finished result
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            pend_r    <= 1'b0;
            rewrite_r <= 1'b0;
        end else begin
            if (start_s) begin
                pend_r <= 1'b1;
            end else if (err_gap_s || arith_done_s) begin
                pend_r <= 1'b0;
            end
            if (err_gap_s) begin
                rewrite_r <= 1'b0;
            end else if (arith_done_s && pend_r) begin
                rewrite_r <= 1'b1;
            end else if (sub_s && (dl_tail_s.pos == PCR_LAST_POS)) begin
                rewrite_r <= 1'b0;
            end
        end
    end

    assign dl_in_s   = '{data: ts_din, en: ts_din_en, sop: ts_din_sop, pos: pos_s};
    assign dl_tail_s = dl_r[LAT-2];

    // Delay line; the output register supplies the last cycle of latency
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            for (int i = 0; i < LAT - 1; i++) begin
                dl_r[i] <= '0;
            end
        end else begin
            dl_r[0] <= dl_in_s;
            for (int i = 1; i < LAT - 1; i++) begin
                dl_r[i] <= dl_r[i-1];
            end
        end
    end

    // Done is folded in directly so byte 6 can be replaced at the minimum LAT
    always_comb begin
        rw_eff_s = !err_gap_s && (rewrite_r || (arith_done_s && pend_r));
        sub_s    = rw_eff_s && dl_tail_s.en && (dl_tail_s.pos != 3'd0);
    end

    // Output registers
    always_ff @(posedge clk_main_a) begin
        if (rst_gen) begin
            dout_r     <= 8'd0;
            dout_en_r  <= 1'b0;
            dout_sop_r <= 1'b0;
            pcr_upd_r  <= 1'b0;
            err_sync_r <= 1'b0;
            err_gap_r  <= 1'b0;
        end else begin
            dout_r     <= sub_s ? pcr_byte_sel(arith_result_s, dl_tail_s.pos) : dl_tail_s.data;
            dout_en_r  <= dl_tail_s.en;
            dout_sop_r <= dl_tail_s.sop;
            pcr_upd_r  <= sub_s && (dl_tail_s.pos == PCR_LAST_POS);
            err_sync_r <= err_sync_s;
            err_gap_r  <= err_gap_s;
        end
    end

    assign ts_dout     = dout_r;
    assign ts_dout_en  = dout_en_r;
    assign ts_dout_sop = dout_sop_r;
    assign pcr_upd     = pcr_upd_r;
    assign err_sync    = err_sync_r;
    assign err_gap     = err_gap_r;

endmodule

// File: tb/tb_pcr_restamp.sv
// Directed bench for pcr_restamp: PCR rewrite, passthrough cases, base wrap,
// sync/gap errors and mid-packet reset, against hand-computed values.
module tb_pcr_restamp;

    localparam int LAT = 8;

    logic        clk_main_a = 1'b0;
    logic        rst_gen    = 1'b1;
    logic [7:0]  ts_din     = 8'd0;
    logic        ts_din_en  = 1'b0;
    logic        ts_din_sop = 1'b0;
    logic [32:0] stamp_base = 33'd0;
    logic [8:0]  stamp_ext  = 9'd0;
    logic [32:0] pcr_base_cnt = 33'd0;
    logic [8:0]  pcr_ext_cnt  = 9'd0;
    logic [7:0]  ts_dout;
    logic        ts_dout_en, ts_dout_sop, pcr_upd, err_sync, err_gap;

    pcr_restamp #(
        .LAT            (LAT),
        .PCR_OFFSET_EXT (9'd8)
    ) dut (
        .clk_main_a   (clk_main_a),
        .rst_gen      (rst_gen),
        .ts_din       (ts_din),
        .ts_din_en    (ts_din_en),
        .ts_din_sop   (ts_din_sop),
        .stamp_base   (stamp_base),
        .stamp_ext    (stamp_ext),
        .pcr_base_cnt (pcr_base_cnt),
        .pcr_ext_cnt  (pcr_ext_cnt),
        .ts_dout      (ts_dout),
        .ts_dout_en   (ts_dout_en),
        .ts_dout_sop  (ts_dout_sop),
        .pcr_upd      (pcr_upd),
        .err_sync     (err_sync),
        .err_gap      (err_gap)
    );

    always #5 clk_main_a = ~clk_main_a;

    int cyc = 0;
    always @(posedge clk_main_a) cyc <= cyc + 1;

    logic [7:0] pkt_buf [0:187];
    logic [7:0] out_buf [0:255];
    int out_cnt = 0, upd_cnt = 0, sync_cnt = 0, gap_cnt = 0;
    int upd_idx = -1, out_sop_cyc = 0, in_sop_cyc = 0;
    int n_checks = 0, n_pass = 0;

    always @(negedge clk_main_a) begin
        if (pcr_upd) begin
            upd_cnt = upd_cnt + 1;
            upd_idx = out_cnt;
        end
        if (ts_dout_en) begin
            if (ts_dout_sop) out_sop_cyc = cyc;
            if (out_cnt < 256) out_buf[out_cnt] = ts_dout;
            out_cnt = out_cnt + 1;
        end
        if (err_sync) sync_cnt = sync_cnt + 1;
        if (err_gap) gap_cnt = gap_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        out_cnt = 0; upd_cnt = 0; sync_cnt = 0; gap_cnt = 0; upd_idx = -1; out_sop_cyc = 0;
    endtask

    task automatic build_pkt(input logic [7:0] b0, input logic [1:0] afc, input logic [7:0] af_len,
                             input logic [7:0] flags, input logic [47:0] pcr48);
        for (int i = 0; i < 188; i++) pkt_buf[i] = 8'(i * 7 + 3);
        pkt_buf[0] = b0;
        pkt_buf[1] = 8'h01;
        pkt_buf[2] = 8'h00;
        pkt_buf[3] = {2'b00, afc, 4'h5};
        pkt_buf[4] = af_len;
        pkt_buf[5] = flags;
        for (int k = 0; k < 6; k++) pkt_buf[6 + k] = pcr48[47 - 8 * k -: 8];
    endtask

    // Drives pkt_buf; optional one-cycle en gap before byte gap_at, stops before byte stop_at
    task automatic send_pkt(input int gap_at, input int stop_at, input logic [32:0] sb,
                            input logic [8:0] se, input logic [32:0] nb, input logic [8:0] ne);
        pcr_base_cnt = nb;
        pcr_ext_cnt  = ne;
        for (int i = 0; i < 188; i++) begin
            if (i == stop_at) break;
            @(posedge clk_main_a); #1;
            if (i == gap_at) begin
                ts_din_en = 1'b0; ts_din_sop = 1'b0;
                @(posedge clk_main_a); #1;
            end
            ts_din     = pkt_buf[i];
            ts_din_en  = 1'b1;
            ts_din_sop = (i == 0);
            if (i == 0) begin
                stamp_base = sb; stamp_ext = se; in_sop_cyc = cyc;
            end
        end
        @(posedge clk_main_a); #1;
        ts_din_en = 1'b0; ts_din_sop = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 6) @(posedge clk_main_a);
        #1;
    endtask

    function automatic int count_diff(input int lo, input int hi);
        int n = 0;
        for (int i = 0; i < 188; i++) begin
            if (!(i >= lo && i <= hi) && out_buf[i] !== pkt_buf[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [47:0] out_pcr();
        return {out_buf[6], out_buf[7], out_buf[8], out_buf[9], out_buf[10], out_buf[11]};
    endfunction

    initial begin
        repeat (3) @(posedge clk_main_a);
        @(negedge clk_main_a);
        check("reset_outs", {ts_dout, ts_dout_en, ts_dout_sop, pcr_upd, err_sync, err_gap}, 64'd0);
        @(posedge clk_main_a); #1;
        rst_gen = 1'b0;

        // PCR (1000,299) stamp (500,10) now (502,5) offset 8 -> (1003,2)
        clear_mon();
        build_pkt(8'h47, 2'd3, 8'd7, 8'h10, {33'd1000, 6'h3F, 9'd299});
        send_pkt(-1, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t1_pcr", out_pcr(), {33'd1003, 6'h3F, 9'd2});
        check("t1_other", count_diff(6, 11), 0);
        check("t1_len", out_cnt, 188);
        check("t1_upd", upd_cnt, 1);
        check("t1_upd_idx", upd_idx, 11);
        check("t1_lat", out_sop_cyc - in_sop_cyc, LAT);
        check("t1_err", sync_cnt + gap_cnt, 0);

        // afc=1: bytes 4..11 look like a PCR AF but must not be parsed
        clear_mon();
        build_pkt(8'h47, 2'd1, 8'd7, 8'h10, {33'd1000, 6'h3F, 9'd299});
        send_pkt(-1, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t2_pass", count_diff(300, 300), 0);
        check("t2_pulses", upd_cnt + sync_cnt + gap_cnt, 0);
        check("t2_lat", out_sop_cyc - in_sop_cyc, LAT);

        clear_mon();
        build_pkt(8'h47, 2'd2, 8'd7, 8'h00, {33'd1000, 6'h3F, 9'd299});
        send_pkt(-1, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t3a_pass", count_diff(300, 300), 0);
        check("t3a_upd", upd_cnt, 0);

        clear_mon();
        build_pkt(8'h47, 2'd3, 8'd0, 8'h10, {33'd1000, 6'h3F, 9'd299});
        send_pkt(-1, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t3b_pass", count_diff(300, 300), 0);
        check("t3b_upd", upd_cnt, 0);

        // Base wrap: stamp (100,20) now (101,12): ext delta 12-20+8 = 0, base delta 1
        clear_mon();
        build_pkt(8'h47, 2'd3, 8'd7, 8'h10, {33'h1_FFFF_FFFF, 6'h3F, 9'd0});
        send_pkt(-1, 188, 33'd100, 9'd20, 33'd101, 9'd12);
        drain();
        check("t4_pcr", out_pcr(), {33'd0, 6'h3F, 9'd0});
        check("t4_upd", upd_cnt, 1);

        clear_mon();
        build_pkt(8'h48, 2'd3, 8'd7, 8'h10, {33'd1000, 6'h3F, 9'd299});
        send_pkt(-1, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t5_sync", sync_cnt, 1);
        check("t5_pass", count_diff(300, 300), 0);
        check("t5_upd", upd_cnt, 0);

        clear_mon();
        build_pkt(8'h47, 2'd3, 8'd7, 8'h10, {33'd1000, 6'h3F, 9'd299});
        send_pkt(8, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t6_gap", gap_cnt, 1);
        check("t6_pass", count_diff(300, 300), 0);
        check("t6_upd", upd_cnt, 0);
        check("t6_len", out_cnt, 188);

        // Reset while output of a packet is in progress
        clear_mon();
        send_pkt(-1, 60, 33'd500, 9'd10, 33'd502, 9'd5);
        check("t7_pre_en", ts_dout_en, 1'b1);
        rst_gen = 1'b1;
        @(posedge clk_main_a);
        @(negedge clk_main_a);
        check("t7_rst", {ts_dout, ts_dout_en, ts_dout_sop, pcr_upd}, 64'd0);
        @(posedge clk_main_a); #1;
        rst_gen = 1'b0;
        repeat (3) @(posedge clk_main_a);
        #1;
        clear_mon();
        send_pkt(-1, 188, 33'd500, 9'd10, 33'd502, 9'd5);
        drain();
        check("t7_pcr", out_pcr(), {33'd1003, 6'h3F, 9'd2});
        check("t7_upd", upd_cnt, 1);
        check("t7_other", count_diff(6, 11), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcr_restamp.md
Name: pcr_restamp

Overview:
- Read-side PCR corrector for the buffered TS path.
- The upstream buffer tags each packet with an arrival time from the local 27 MHz PCR counter (base 33-bit, ext mod 300) when it writes the packet.
- This block reads packets out, parses the header and adaptation field, and rewrites any PCR with PCR_in + (now − arrival) + PCR_OFFSET_EXT.
- All other bytes pass unchanged, with a fixed latency.

Parameters:
- LAT, 8, output delay in clk_main_a cycles (LAT ≥ 8).
- PCR_OFFSET_EXT, 9'd8, constant added to the ext delta to cover pipeline delay, in 27 MHz ticks (0..299).

Ports:
- clk_main_a  in  1  system clock
- rst_gen  in  1  reset, synchronous, active-high
- ts_din  in  8  TS byte in
- ts_din_en  in  1  byte valid
- ts_din_sop  in  1  first byte of packet; qualified by ts_din_en
- stamp_base  in  33  arrival base; valid with ts_din_sop
- stamp_ext  in  9  arrival ext (0..299); valid with ts_din_sop
- pcr_base_cnt  in  33  live local counter base
- pcr_ext_cnt  in  9  live local counter ext
- ts_dout  out  8  TS byte out
- ts_dout_en  out  1  byte valid out
- ts_dout_sop  out  1  first byte out
- pcr_upd  out  1  1-cycle pulse as the last rewritten PCR byte (index 11) is output
- err_sync  out  1  1-cycle pulse: byte 0 ≠ 0x47
- err_gap  out  1  1-cycle pulse: ts_din_en low mid-packet

Behaviour:
- Reset: all outputs 0; FSM to IDLE; byte index 0; delay line cleared (en/sop bits 0).
- Data path: ts_din, ts_din_en and ts_din_sop are delayed exactly LAT cycles (pure cycle delay). Bytes 6..11 are substituted at the output when the rewrite flag is set for that packet.
- Input protocol: 188 contiguous en cycles per packet; gaps only between packets.
- Index counting: idx counts 0..187 on en. Sop with en forces idx=0, latches stamp_base/ext and restarts the FSM, even mid-packet.
- FSM states: IDLE, HDR, AF_LEN, AF_FLAGS, PCR_CAP, PAYLOAD.
  - IDLE → HDR on sop if byte==0x47. Otherwise pulse err_sync and go to PAYLOAD; no rewrite.
  - HDR: idx 1..3. At idx 3, afc=byte[5:4]. If afc is 2 or 3 → AF_LEN, else → PAYLOAD.
  - AF_LEN: idx 4. Length 0 → PAYLOAD, else → AF_FLAGS.
  - AF_FLAGS: idx 5. byte[4] (PCR_flag) set → PCR_CAP, else → PAYLOAD.
  - PCR_CAP: idx 6..11. Shift the 6 bytes into a 48-bit reg: base=[47:15], reserved=[14:9], ext=[8:0]. At idx 11, sample pcr_base_cnt/pcr_ext_cnt as "now" → PAYLOAD and start the arithmetic.
  - PAYLOAD: at idx 187 → IDLE.
- Error handling: en low while idx is 1..187 → pulse err_gap, clear the rewrite flag, go to IDLE (remaining bytes pass unmodified).
- Arithmetic: 2 registered stages, done before byte 6 leaves the delay line (guaranteed by LAT ≥ 8 with contiguous input).
  - Stage 1: d_ext = now_ext − stamp_ext + PCR_OFFSET_EXT, normalised to 0..299 with a borrow/carry into d_base = now_base − stamp_base (mod 2^33).
  - Stage 2: s_ext = pcr_ext + d_ext. If s_ext ≥ 300, subtract 300 and carry 1. s_base = pcr_base + d_base + carry, mod 2^33.
- Counter wrap: base wrap at 2^33 is handled by modular subtraction. Ext inputs > 299 are treated as-is; no check.
- Rewrite: set when stage 2 completes.
  - Output bytes 6..11 = {s_base, reserved_in, s_ext} MSB first; reserved bits are preserved.
  - The flag clears on output of byte 11, when pcr_upd pulses.
- Simultaneous events: a new input sop while an earlier packet's rewrite is pending at the output is legal. Per-packet flags travel in the delay line alongside the data.

Decomposition:
- Shared package pcr_pkg: TS_SYNC=8'h47, TS_PKT_LEN=188, PCR_EXT_MOD=300, the FSM state encoding, and PCR byte offsets 6/11.
- One sub-module pcr_arith holds the two-stage mod-300/mod-2^33 subtract-then-add pipeline:
  - inputs: pcr, stamp, now, start
  - outputs: result, done

Test Plan:
- Packet with afc=3, af_len=7, flags=0x10, PCR base=1000 ext=299; stamp=(500,10); now=(502,5); offset=8:
  - d=(1,303)→(2,3); ext 299+3=302 → ext 2, carry 1 → base 1003.
  - Bytes 6..11 rewritten; pcr_upd pulses once.
- afc=1 packet → output identical to input, delayed LAT; no pulses.
- afc=2 with flags=0x00, and af_len=0 → passthrough, no pcr_upd.
- Base wrap: PCR base=2^33−1 ext=0; delta base 1, ext 0 (offset 0) → base 0, ext 0; reserved bits 0x3F preserved.
- Byte 0 = 0x48 → err_sync pulse, full passthrough. en dropped at idx 8 → err_gap pulse, no rewrite.
- Reset asserted mid-packet → outputs 0 the next cycle. The following valid PCR packet is rewritten correctly.
